// File: rtl/arith_pkg.sv
// Shared arithmetic constants and the serial-adder state type.
package arith_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_state_t;

endpackage

// File: rtl/ripplecarryadder.sv
// Combinational 4-bit ripple-carry adder; the only adder in the serial datapath.
module ripplecarryadder
  import arith_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W:0] carry;

  always_comb begin
    carry    = '0;
    s        = '0;
    carry[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder processed one nibble per cycle, LSB first, with valid/ready on both sides.
module nibble_serial_adder
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
    $fatal(1, "nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  serial_state_t state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [WIDTH-1:0]    a_q, b_q, sum_q;
  logic                carry_q, a_msb_q, b_msb_q, cout_q, ovf_q;
  logic [NIBBLE_W-1:0] nib_s;
  logic                nib_cout;
  logic                last;
  logic [WIDTH-1:0]    sum_shift;

  ripplecarryadder u_rca (
    .a    (a_q[NIBBLE_W-1:0]),
    .b    (b_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_cout)
  );

  assign last = (cnt_q == CNT_W'(NIBBLES - 1));
  // New sum nibble enters at the top so the LSB nibble lands at bit 0 after NIBBLES shifts.
  assign sum_shift = (sum_q >> NIBBLE_W) | (WIDTH'(nib_s) << (WIDTH - NIBBLE_W));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> NIBBLE_W;
          b_q     <= b_q >> NIBBLE_W;
          sum_q   <= sum_shift;
          carry_q <= nib_cout;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last) begin
            cout_q <= nib_cout;
            ovf_q  <= (a_msb_q == b_msb_q) && (nib_s[NIBBLE_W-1] != a_msb_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench: 16-bit directed/random ops plus free-running 4- and 32-bit instances.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // 16-bit DUT
  logic        in_valid, in_ready, out_valid, out_ready, cin, cout, ovf;
  logic [15:0] a, b, s;
  logic [17:0] q16[$];
  int          acc_cyc;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
  );

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w16_unexpected_result actual=%0h required=none", s);
      end else begin
        logic [17:0] e;
        e = q16.pop_front();
        chk("w16_s", 64'(s), 64'(e[15:0]));
        chk("w16_cout", 64'(cout), 64'(e[16]));
        chk("w16_ovf", 64'(ovf), 64'(e[17]));
      end
    end
  end

  // Drive an op and return #1 after its acceptance edge; in_valid stays high if hold is set.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb2, input logic tc,
                       input bit push, input logic [15:0] es, input logic ec, input logic eo,
                       input bit hold);
    int n;
    a = ta; b = tb2; cin = tc; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL w16_accept_timeout actual=%0d required=<50", n);
    end else begin
      @(posedge clk);
      if (push) q16.push_back({eo, ec, es});
      #1;
      acc_cyc = cyc;
      if (!hold) in_valid = 1'b0;
    end
  endtask

  // Free-running 4- and 32-bit instances with a model-based scoreboard
  logic        aux_en = 1'b0;
  logic        rdy4, ov4, co4, of4, c4, rdy32, ov32, co32, of32, c32;
  logic [3:0]  a4, b4, s4;
  logic [31:0] a32, b32, s32;
  logic [5:0]  q4[$];
  logic [33:0] q32[$];
  int          acc4, acc32, n4 = 0, n32 = 0;

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(aux_en), .in_ready(rdy4), .a(a4), .b(b4),
    .cin(c4), .out_valid(ov4), .out_ready(1'b1), .s(s4), .cout(co4), .ovf(of4)
  );

  nibble_serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(aux_en), .in_ready(rdy32), .a(a32), .b(b32),
    .cin(c32), .out_valid(ov32), .out_ready(1'b1), .s(s32), .cout(co32), .ovf(of32)
  );

  always @(posedge clk) begin
    if (rst_n && aux_en && rdy4) begin
      logic [4:0] t;
      t = {1'b0, a4} + {1'b0, b4} + 5'(c4);
      q4.push_back({(a4[3] == b4[3]) && (t[3] != a4[3]), t});
      acc4 = cyc + 1;
    end
    if (rst_n && aux_en && rdy32) begin
      logic [32:0] t;
      t = {1'b0, a32} + {1'b0, b32} + 33'(c32);
      q32.push_back({(a32[31] == b32[31]) && (t[31] != a32[31]), t});
      acc32 = cyc + 1;
    end
    #1;
    a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
    a32 = $urandom; b32 = $urandom; c32 = 1'($urandom);
  end

  always @(negedge clk) begin
    if (rst_n && ov4) begin
      logic [5:0] e;
      n4++;
      chk("w4_latency", 64'(cyc - acc4), 64'd1);
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w4_unexpected_result actual=%0h required=none", s4);
      end else begin
        e = q4.pop_front();
        chk("w4_result", 64'({of4, co4, s4}), 64'(e));
      end
    end
    if (rst_n && ov32) begin
      logic [33:0] e;
      n32++;
      chk("w32_latency", 64'(cyc - acc32), 64'd8);
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w32_unexpected_result actual=%0h required=none", s32);
      end else begin
        e = q32.pop_front();
        chk("w32_result", 64'({of32, co32, s32}), 64'(e));
      end
    end
  end

  initial begin
    int          prev;
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] t;
    int          n;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_s", 64'(s), 64'd0);
    chk("reset_cout_ovf", 64'({cout, ovf}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add with latency check
    do_op(16'h1234, 16'h4321, 1'b0, 1, 16'h5555, 1'b0, 1'b0, 0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk("lat_not_yet", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    chk("lat_valid_at_4", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    do_op(16'hFFFF, 16'h0000, 1'b1, 1, 16'h0000, 1'b1, 1'b0, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1, 16'h8000, 1'b0, 1'b1, 0);
    do_op(16'h8000, 16'h8000, 1'b0, 1, 16'h0000, 1'b1, 1'b1, 0);

    // Stall in DONE with a new op waiting
    repeat (8) @(posedge clk);
    #1;
    out_ready = 1'b0;
    do_op(16'h1111, 16'h2222, 1'b0, 1, 16'h3333, 1'b0, 1'b0, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_reached_done", 64'(out_valid), 64'd1);
    a = 16'h0001; b = 16'h0002; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_s", 64'(s), 64'h3333);
      chk("stall_cout_ovf", 64'({cout, ovf}), 64'd0);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    do_op(16'h0001, 16'h0002, 1'b0, 1, 16'h0003, 1'b0, 1'b0, 0);
    repeat (8) @(posedge clk);
    #1;

    // Reset in the middle of RUN
    do_op(16'h5555, 16'h1111, 1'b1, 0, 16'h0, 1'b0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_s", 64'(s), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(16'h0F0F, 16'h0101, 1'b0, 1, 16'h1010, 1'b0, 1'b0, 0);
    repeat (8) @(posedge clk);
    #1;

    // Back-to-back random ops; all three widths run concurrently
    aux_en = 1'b1;
    prev = 0;
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      t = {1'b0, ra} + {1'b0, rb} + 17'(rc);
      do_op(ra, rb, rc, 1, t[15:0], t[16], (ra[15] == rb[15]) && (t[15] != ra[15]), 1);
      if (i > 0) chk("throughput_period", 64'(acc_cyc - prev), 64'd6);
      prev = acc_cyc;
    end
    in_valid = 1'b0;
    aux_en = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("drain_q16", 64'(q16.size()), 64'd0);
    chk("drain_q4", 64'(q4.size()), 64'd0);
    chk("drain_q32", 64'(q32.size()), 64'd0);
    chk("w4_results_seen", 64'(n4 > 100), 64'd1);
    chk("w32_results_seen", 64'(n32 > 50), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
